// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, direct-mapped I-cache with request/ready refill, IF/ID register.
// Optional hit/miss counters are enabled by defining ICACHE_PERF_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned LINES    = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         fetch_en,
  input  logic         branch_taken,
  input  logic [31:0]  branch_target,
  output logic         mem_req,
  output logic [31:0]  mem_addr,
  input  logic         mem_ready,
  input  logic [127:0] mem_data,
  output logic [31:0]  instruction,
  output logic [31:0]  pc_out,
  output logic         block_pipe_instr_cache
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
`endif
);

  localparam int unsigned IndexW = $clog2(LINES);
  localparam int unsigned TagW   = 28 - IndexW;

  typedef enum logic [0:0] {StIdle, StRefill} state_e;
  typedef logic [3:0][31:0] line_t;

  state_e            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic [31:0]       pc_out_q, pc_out_d;
  logic [31:0]       miss_addr_q, miss_addr_d;
  logic [LINES-1:0]  valid_q, valid_d;
  line_t             data_q [LINES];
  logic [TagW-1:0]   tag_q  [LINES];

  logic [IndexW-1:0] idx, fill_idx;
  logic [TagW-1:0]   tag, fill_tag;
  logic [1:0]        off;
  logic              hit, fill;
  logic              unused_tgt_bits;

  assign idx      = pc_q[4 +: IndexW];
  assign tag      = pc_q[31:4+IndexW];
  assign off      = pc_q[3:2];
  assign fill_idx = miss_addr_q[4 +: IndexW];
  assign fill_tag = miss_addr_q[31:4+IndexW];

  assign hit  = (state_q == StIdle) && valid_q[idx] && (tag_q[idx] == tag);
  assign fill = (state_q == StRefill) && mem_ready;

  assign unused_tgt_bits = ^branch_target[1:0];

  // A branch in IDLE suppresses the miss, so the stall only covers real lookups.
  assign block_pipe_instr_cache = (state_q == StRefill) || !(hit || branch_taken);
  assign mem_req     = (state_q == StRefill);
  assign mem_addr    = miss_addr_q;
  assign instruction = instr_q;
  assign pc_out      = pc_out_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    pc_out_d    = pc_out_q;
    miss_addr_d = miss_addr_q;
    valid_d     = valid_q;

    if (fill) valid_d[fill_idx] = 1'b1;

    if (branch_taken) begin
      pc_d     = {branch_target[31:2], 2'b00};
      instr_d  = 32'h0;
      pc_out_d = pc_q;
    end else if (hit) begin
      if (fetch_en) begin
        instr_d  = data_q[idx][off];
        pc_out_d = pc_q;
        pc_d     = pc_q + 32'd4;
      end
    end else if (fetch_en) begin
      instr_d  = 32'h0;
      pc_out_d = pc_q;
    end

    unique case (state_q)
      StIdle: begin
        if (!hit && !branch_taken) begin
          state_d     = StRefill;
          miss_addr_d = {pc_q[31:4], 4'b0000};
        end
      end
      StRefill: begin
        if (mem_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      pc_q        <= RESET_PC;
      instr_q     <= 32'h0;
      pc_out_q    <= RESET_PC;
      miss_addr_q <= 32'h0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      pc_out_q    <= pc_out_d;
      miss_addr_q <= miss_addr_d;
      valid_q     <= valid_d;
      // Line payload needs no reset: valid bits gate every use.
      if (fill) begin
        data_q[fill_idx] <= mem_data;
        tag_q[fill_idx]  <= fill_tag;
      end
    end
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (hit && fetch_en && !branch_taken) hit_cnt_d = hit_cnt_q + 32'd1;
    if ((state_q == StIdle) && (state_d == StRefill)) miss_cnt_d = miss_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_cnt_q  <= 32'h0;
      miss_cnt_q <= 32'h0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: vector table for cold start/hold/eviction, plus hand-written
// sequences for branch-during-refill, reset-during-refill and (with ICACHE_PERF_EN) counters.
module tb_fetch_stage;

  localparam logic [4:0] CB = 5'b00001;  // block_pipe_instr_cache
  localparam logic [4:0] CR = 5'b00010;  // mem_req
  localparam logic [4:0] CA = 5'b00100;  // mem_addr
  localparam logic [4:0] CI = 5'b01000;  // instruction
  localparam logic [4:0] CP = 5'b10000;  // pc_out
  localparam logic [4:0] ALL = 5'b11111;

  localparam logic [127:0] LINE0 = {32'd13, 32'd12, 32'd11, 32'd10};
  localparam logic [127:0] LINE1 = {32'd23, 32'd22, 32'd21, 32'd20};
  localparam logic [127:0] LINE2 = {32'd33, 32'd32, 32'd31, 32'd30};
  localparam logic [127:0] LINE3 = {32'd43, 32'd42, 32'd41, 32'd40};

  typedef struct {
    logic         rst;
    logic         fe;
    logic         br;
    logic [31:0]  tgt;
    logic         rdy;
    logic [127:0] data;
    logic [4:0]   chk;
    logic         eb;
    logic         er;
    logic [31:0]  ea;
    logic [31:0]  ei;
    logic [31:0]  ep;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset, fetch_en, branch_taken, mem_ready;
  logic [31:0]  branch_target;
  logic [127:0] mem_data;
  logic         mem_req, block_pipe_instr_cache;
  logic [31:0]  mem_addr, instruction, pc_out;
`ifdef ICACHE_PERF_EN
  logic [31:0]  hit_count, miss_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int row      = 0;
  string seq   = "";

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk                    (clk),
    .reset                  (reset),
    .fetch_en               (fetch_en),
    .branch_taken           (branch_taken),
    .branch_target          (branch_target),
    .mem_req                (mem_req),
    .mem_addr               (mem_addr),
    .mem_ready              (mem_ready),
    .mem_data               (mem_data),
    .instruction            (instruction),
    .pc_out                 (pc_out),
    .block_pipe_instr_cache (block_pipe_instr_cache)
`ifdef ICACHE_PERF_EN
    ,
    .hit_count              (hit_count),
    .miss_count             (miss_count)
`endif
  );

  function automatic vec_t mk(input logic rst, input logic fe, input logic br,
                              input logic [31:0] tgt, input logic rdy, input logic [127:0] data,
                              input logic [4:0] chk, input logic eb, input logic er,
                              input logic [31:0] ea, input logic [31:0] ei,
                              input logic [31:0] ep);
    vec_t v;
    v.rst = rst; v.fe = fe; v.br = br; v.tgt = tgt; v.rdy = rdy; v.data = data;
    v.chk = chk; v.eb = eb; v.er = er; v.ea = ea; v.ei = ei; v.ep = ep;
    return v;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d %s: got %h expected %h", seq, row, name, act, exp);
    end
  endtask

  // Drive inputs after the falling edge, check just after; the next rising edge consumes them.
  task automatic step(input vec_t v);
    @(negedge clk);
    reset         = v.rst;
    fetch_en      = v.fe;
    branch_taken  = v.br;
    branch_target = v.tgt;
    mem_ready     = v.rdy;
    mem_data      = v.data;
    #1;
    if (v.chk[0]) check32("block", {31'b0, block_pipe_instr_cache}, {31'b0, v.eb});
    if (v.chk[1]) check32("mem_req", {31'b0, mem_req}, {31'b0, v.er});
    if (v.chk[2]) check32("mem_addr", mem_addr, v.ea);
    if (v.chk[3]) check32("instruction", instruction, v.ei);
    if (v.chk[4]) check32("pc_out", pc_out, v.ep);
    row++;
  endtask

  vec_t tbl [21];

  initial begin
    reset = 1'b1; fetch_en = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    mem_ready = 1'b0; mem_data = '0;

    // Cold start, fetch_en hold, conflict eviction between 0x00 and 0x40.
    tbl[0]  = mk(1, 1, 0, 32'h0,  0, '0,    5'b0,         0, 0, 32'h0,  32'h0,  32'h0);
    tbl[1]  = mk(0, 1, 0, 32'h0,  0, '0,    CB|CR|CI|CP,  1, 0, 32'h0,  32'h0,  32'h0);
    tbl[2]  = mk(0, 1, 0, 32'h0,  0, '0,    ALL,          1, 1, 32'h0,  32'h0,  32'h0);
    tbl[3]  = mk(0, 1, 0, 32'h0,  0, '0,    ALL,          1, 1, 32'h0,  32'h0,  32'h0);
    tbl[4]  = mk(0, 1, 0, 32'h0,  1, LINE0, ALL,          1, 1, 32'h0,  32'h0,  32'h0);
    tbl[5]  = mk(0, 1, 0, 32'h0,  0, '0,    CB|CR|CI|CP,  0, 0, 32'h0,  32'h0,  32'h0);
    tbl[6]  = mk(0, 1, 0, 32'h0,  0, '0,    CB|CI|CP,     0, 0, 32'h0,  32'd10, 32'h0);
    tbl[7]  = mk(0, 1, 0, 32'h0,  0, '0,    CB|CI|CP,     0, 0, 32'h0,  32'd11, 32'h4);
    tbl[8]  = mk(0, 0, 0, 32'h0,  0, '0,    CB|CI|CP,     0, 0, 32'h0,  32'd12, 32'h8);
    tbl[9]  = mk(0, 0, 0, 32'h0,  0, '0,    CB|CI|CP,     0, 0, 32'h0,  32'd12, 32'h8);
    tbl[10] = mk(0, 0, 0, 32'h0,  0, '0,    CB|CI|CP,     0, 0, 32'h0,  32'd12, 32'h8);
    tbl[11] = mk(0, 1, 0, 32'h0,  0, '0,    CB|CI|CP,     0, 0, 32'h0,  32'd12, 32'h8);
    tbl[12] = mk(0, 1, 1, 32'h40, 0, '0,    CR|CI|CP,     0, 0, 32'h0,  32'd13, 32'hc);
    tbl[13] = mk(0, 1, 0, 32'h0,  0, '0,    CB|CR|CI,     1, 0, 32'h0,  32'h0,  32'h0);
    tbl[14] = mk(0, 1, 0, 32'h0,  1, LINE1, ALL,          1, 1, 32'h40, 32'h0,  32'h40);
    tbl[15] = mk(0, 1, 0, 32'h0,  0, '0,    CB|CR|CI|CP,  0, 0, 32'h0,  32'h0,  32'h40);
    tbl[16] = mk(0, 1, 1, 32'h3,  0, '0,    CB|CI|CP,     0, 0, 32'h0,  32'd20, 32'h40);
    tbl[17] = mk(0, 1, 0, 32'h0,  0, '0,    CB|CR|CI,     1, 0, 32'h0,  32'h0,  32'h0);
    tbl[18] = mk(0, 1, 0, 32'h0,  1, LINE0, ALL,          1, 1, 32'h0,  32'h0,  32'h0);
    tbl[19] = mk(0, 1, 0, 32'h0,  0, '0,    CB|CR|CI|CP,  0, 0, 32'h0,  32'h0,  32'h0);
    tbl[20] = mk(0, 1, 0, 32'h0,  0, '0,    CB|CI|CP,     0, 0, 32'h0,  32'd10, 32'h0);

    seq = "table"; row = 0;
    for (int i = 0; i < 21; i++) step(tbl[i]);

    // Branch to 0x104 while line 0x10 is refilling: transfer completes, then 0x100 is fetched.
    seq = "br_refill"; row = 0;
    step(mk(1, 1, 0, 32'h0,   0, '0,    5'b0,        0, 0, 32'h0,   32'h0,  32'h0));
    step(mk(0, 1, 1, 32'h10,  0, '0,    CR|CI|CP,    0, 0, 32'h0,   32'h0,  32'h0));
    step(mk(0, 1, 0, 32'h0,   0, '0,    CB|CR|CI,    1, 0, 32'h0,   32'h0,  32'h0));
    step(mk(0, 1, 1, 32'h104, 0, '0,    ALL,         1, 1, 32'h10,  32'h0,  32'h10));
    step(mk(0, 1, 0, 32'h0,   1, LINE2, CB|CR|CA,    1, 1, 32'h10,  32'h0,  32'h0));
    step(mk(0, 1, 0, 32'h0,   0, '0,    CB|CR|CI,    1, 0, 32'h0,   32'h0,  32'h0));
    step(mk(0, 1, 0, 32'h0,   1, LINE3, CB|CR|CA,    1, 1, 32'h100, 32'h0,  32'h0));
    step(mk(0, 1, 0, 32'h0,   0, '0,    CB|CR,       0, 0, 32'h0,   32'h0,  32'h0));
    step(mk(0, 1, 1, 32'h10,  0, '0,    CI|CP,       0, 0, 32'h0,   32'd41, 32'h104));
    step(mk(0, 1, 0, 32'h0,   0, '0,    CB|CR,       0, 0, 32'h0,   32'h0,  32'h0));
    step(mk(0, 1, 0, 32'h0,   0, '0,    CI|CP,       0, 0, 32'h0,   32'd30, 32'h10));

    // Reset lands in REFILL together with mem_ready: the line must not be installed.
    seq = "rst_refill"; row = 0;
    step(mk(1, 1, 0, 32'h0, 0, '0,    5'b0,         0, 0, 32'h0, 32'h0, 32'h0));
    step(mk(0, 1, 0, 32'h0, 0, '0,    CB|CR,        1, 0, 32'h0, 32'h0, 32'h0));
    step(mk(0, 1, 0, 32'h0, 0, '0,    CR|CA,        0, 1, 32'h0, 32'h0, 32'h0));
    step(mk(1, 1, 0, 32'h0, 1, LINE0, CR,           0, 1, 32'h0, 32'h0, 32'h0));
    step(mk(0, 1, 0, 32'h0, 0, '0,    CB|CR|CI|CP,  1, 0, 32'h0, 32'h0, 32'h0));
    step(mk(0, 1, 0, 32'h0, 0, '0,    CR|CA,        0, 1, 32'h0, 32'h0, 32'h0));

`ifdef ICACHE_PERF_EN
    // Cold start plus seven sequential hits (0x0..0xc, then 0x10..0x18 after a second miss).
    seq = "perf"; row = 0;
    step(mk(1, 1, 0, 32'h0, 1, LINE0, 5'b0, 0, 0, 32'h0, 32'h0, 32'h0));
    check32("hit_count_rst", hit_count, 32'd0);
    check32("miss_count_rst", miss_count, 32'd0);
    for (int i = 0; i < 11; i++) step(mk(0, 1, 0, 32'h0, 1, LINE0, 5'b0, 0, 0, 0, 0, 0));
    step(mk(0, 0, 0, 32'h0, 0, '0, CB|CR, 0, 0, 32'h0, 32'h0, 32'h0));
    check32("hit_count", hit_count, 32'd7);
    check32("miss_count", miss_count, 32'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
